stopwatch_lap_timer: RTL and testbench
======================================

# stopwatch_lap_timer

Parametrised successor to the board stopwatch. It debounces active-low keys and keeps an mm:ss.cc BCD time counter that counts up or down, driven by a configurable clock prescaler. It captures split times into a lap buffer with recall, and raises an alarm when a countdown expires. It sits between the raw keys and the existing per-digit seven-segment decoders, which consume its packed BCD display bus.

## Interface
- CLK_PER_TICK, 500000, clk cycles per 10 ms tick (50 MHz); legal range ≥ 2
- DEBOUNCE_CYCLES, 255, consecutive stable samples needed to accept a key change; legal range ≥ 2
- LAP_DEPTH, 4, lap buffer entries; legal range ≥ 1
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- key_reset  in  1  raw key, active-low (0 = pressed)
- key_start_pause  in  1  raw key, active-low
- key_lap  in  1  raw key, active-low
- countdown  in  1  mode select: 1 = count down, 0 = count up; latched only on a reset event
- preset_bcd  in  24  countdown start value {mm_h, mm_l, ss_h, ss_l, cc_h, cc_l}, 4 bits per digit
- display_bcd  out  24  shown time, same packing as preset_bcd
- running  out  1  time counter is advancing
- lap_count  out  $clog2(LAP_DEPTH+1)  number of stored laps
- lap_view  out  1  display_bcd is showing a stored lap, not the live time
- alarm  out  1  countdown expired; held until cleared
- tick  out  1  one-cycle pulse on each counter update

## Operation
- **Reset values (rst=1, applied asynchronously):**
  - display_bcd, time counter, prescaler, lap_count, view index: 0
  - running, lap_view, alarm, tick: 0
  - mode: up
  - debounced key states: released (1)
  - lap buffer contents: don't-care
- **Debounce (per key):**
  - The counter increments while the raw key differs from its debounced state, and clears on any matching sample.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced state flips and the counter clears.
  - A debounced 1→0 flip produces a one-cycle press event. Releases produce no event.
- **Event priority when several occur in the same cycle:** reset > start_pause > lap.
- **Reset event:**
  - Ignored while running.
  - Otherwise: latch the countdown input into the mode register.
  - Load the counter: 0 in up mode, or preset_bcd in down mode. When loading the preset, digits > 9 load as 9 and ss_h > 5 loads as 5.
  - Clear prescaler, lap_count, lap_view and alarm.
- **Start/pause event:**
  - Toggles running.
  - Clears alarm.
  - Starting forces lap_view=0.
  - In down mode, a start while the counter is 00:00.00 is ignored, except that alarm is still cleared.
- **Prescaler:**
  - Counts 0..CLK_PER_TICK-1 while running and wraps.
  - At the terminal count it asserts tick and updates the counter.
  - Holds its value while paused.
- **Up counting:**
  - cc 00→99, carries into ss 00→59, carries into mm 00→99.
  - 99:59.99 wraps to 00:00.00 and keeps running.
- **Down counting:**
  - Borrows mirror the up-counting ranges.
  - When the counter reaches 00:00.00, at that same edge: running←0 and alarm←1.
- **Lap event while running:**
  - If lap_count < LAP_DEPTH, write the pre-edge counter value to entry lap_count and increment lap_count.
  - When the buffer is full, the capture is dropped and lap_count holds at LAP_DEPTH.
- **Lap event while stopped:**
  - With lap_count = 0: no effect.
  - Otherwise it steps the view: live → lap 0 → … → lap lap_count-1 → live.
  - lap_view=1 whenever a stored entry is shown.
- **display_bcd:** the selected lap entry when lap_view=1, otherwise the live counter.

## Timing
- The first edge that samples a key low is edge 1.
  - The debounced state falls at edge DEBOUNCE_CYCLES.
  - The press event is high during the following cycle.
  - The effect (running, lap_count, etc.) is visible after edge DEBOUNCE_CYCLES+1.
- Tick period is exactly CLK_PER_TICK cycles of running time. Pausing and resuming preserves the phase within the current tick.
- tick and the counter update are registered on the same edge. display_bcd reflects the new value in the same cycle tick is high.
- **Pause and tick on the same edge:** the counter update is applied, then running←0.
- **Lap capture and tick on the same edge:** the entry stores the pre-update value.
- **Reset or start event on the same edge as expiry:** the expiry update is applied first; the event then acts on the stopped state.
- All outputs are registered; there is no combinational path from the keys to the outputs.

## Test plan
All scenarios use CLK_PER_TICK=4, DEBOUNCE_CYCLES=3, LAP_DEPTH=2.
- **Debounce:** key_start_pause low for 2 cycles, then high → running stays 0. Low for 3 cycles → running=1 after edge 4, with the first tick 4 cycles later.
- **Up wrap:** force the counter to 99:59.99 while running → the next tick gives 00:00.00, running stays 1, alarm stays 0.
- **Countdown:** countdown=1, preset 00:00.02, reset event, start → ticks show 00:00.01 then 00:00.00. At that edge running=0 and alarm=1. A further start press leaves running=0 and sets alarm=0.
- **Preset clamp:** preset digits {A,3,7,F,2,2}, down mode, reset event → display 93:59.22.
- **Laps:** run, lap at 00:00.03, 00:00.05 and 00:00.07 → lap_count=2 and the third capture is dropped. Pause, then three lap presses → display shows 00:00.03 (lap_view=1), then 00:00.05, then live (lap_view=0).
- **Priority and async reset:** reset and start_pause events in the same cycle while stopped → reset applied and running=1. Assert rst mid-tick → all outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/stopwatch_lap_timer.sv
// Stopwatch / countdown timer with debounced active-low keys, mm:ss.cc BCD counter,
// lap capture buffer with recall, and countdown-expiry alarm.
module stopwatch_lap_timer #(
  parameter int unsigned CLK_PER_TICK    = 500000,
  parameter int unsigned DEBOUNCE_CYCLES = 255,
  parameter int unsigned LAP_DEPTH       = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               key_reset,
  input  logic                               key_start_pause,
  input  logic                               key_lap,
  input  logic                               countdown,
  input  logic [23:0]                        preset_bcd,
  output logic [23:0]                        display_bcd,
  output logic                               running,
  output logic [$clog2(LAP_DEPTH+1)-1:0]     lap_count,
  output logic                               lap_view,
  output logic                               alarm,
  output logic                               tick
);

  localparam int unsigned PreW = $clog2(CLK_PER_TICK);
  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LcW  = $clog2(LAP_DEPTH + 1);
  localparam int unsigned IdxW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

  localparam int KeyRst = 0;
  localparam int KeySp  = 1;
  localparam int KeyLap = 2;

  // Largest legal value of BCD digit i (digit 3 is the tens of seconds).
  function automatic logic [3:0] digit_max(input int i);
    return (i == 3) ? 4'd5 : 4'd9;
  endfunction

  // One up or down step across all six digits, rippling carry/borrow upward.
  function automatic logic [23:0] bcd_step(input logic [23:0] t, input logic down);
    logic [23:0] r;
    logic        c;
    logic [3:0]  d;
    r = t;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = t[4*i +: 4];
      if (c) begin
        if (down) begin
          if (d == 4'd0) begin
            d = digit_max(i);
          end else begin
            d = d - 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d >= digit_max(i)) begin
            d = 4'd0;
          end else begin
            d = d + 4'd1;
            c = 1'b0;
          end
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  function automatic logic [23:0] bcd_clamp(input logic [23:0] t);
    logic [23:0] r;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = (t[4*i +: 4] > digit_max(i)) ? digit_max(i) : t[4*i +: 4];
    end
    return r;
  endfunction

  // Debounce state
  logic [2:0]          key_raw;
  logic [2:0]          key_db_q, key_db_d;
  logic [2:0][DbW-1:0] db_cnt_q, db_cnt_d;
  logic [2:0]          press_q, press_d;

  // Timer state
  logic [PreW-1:0] pre_q, pre_d;
  logic [23:0]     count_q, count_d;
  logic            mode_q, mode_d;
  logic            running_q, running_d;
  logic            alarm_q, alarm_d;
  logic            tick_q, tick_d;
  logic [LcW-1:0]  lap_count_q, lap_count_d;
  logic            lap_view_q, lap_view_d;
  logic [IdxW-1:0] view_idx_q, view_idx_d;
  logic [23:0]     display_q, display_d;

  logic [23:0]     lap_buf_q [LAP_DEPTH];
  logic            lap_wr;
  logic [LcW-1:0]  lap_wr_idx;
  logic [23:0]     lap_data;
  logic [23:0]     lap_sel;
  logic [23:0]     step;

  assign key_raw = {key_lap, key_start_pause, key_reset};

  always_comb begin
    key_db_d = key_db_q;
    db_cnt_d = '0;
    press_d  = '0;
    for (int k = 0; k < 3; k++) begin
      if (key_raw[k] != key_db_q[k]) begin
        if (db_cnt_q[k] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          key_db_d[k] = key_raw[k];
          press_d[k]  = ~key_raw[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // Expiry is resolved first, then reset, start/pause and lap events act in that order.
  always_comb begin
    pre_d       = pre_q;
    count_d     = count_q;
    mode_d      = mode_q;
    running_d   = running_q;
    alarm_d     = alarm_q;
    tick_d      = 1'b0;
    lap_count_d = lap_count_q;
    lap_view_d  = lap_view_q;
    view_idx_d  = view_idx_q;
    lap_wr      = 1'b0;
    lap_wr_idx  = lap_count_q;
    lap_data    = count_q;
    step        = bcd_step(count_q, mode_q);

    if (running_q) begin
      if (pre_q == PreW'(CLK_PER_TICK - 1)) begin
        pre_d   = '0;
        tick_d  = 1'b1;
        count_d = step;
        if (mode_q && (step == 24'd0)) begin
          running_d = 1'b0;
          alarm_d   = 1'b1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    if (press_q[KeyRst] && !running_d) begin
      mode_d      = countdown;
      count_d     = countdown ? bcd_clamp(preset_bcd) : 24'd0;
      lap_data    = count_d;
      pre_d       = '0;
      lap_count_d = '0;
      lap_view_d  = 1'b0;
      view_idx_d  = '0;
      alarm_d     = 1'b0;
    end

    if (press_q[KeySp]) begin
      alarm_d = 1'b0;
      if (running_d) begin
        running_d = 1'b0;
      end else if (!(mode_d && (count_d == 24'd0))) begin
        running_d  = 1'b1;
        lap_view_d = 1'b0;
        view_idx_d = '0;
      end
    end

    if (press_q[KeyLap]) begin
      if (running_d) begin
        if (lap_count_d < LcW'(LAP_DEPTH)) begin
          lap_wr      = 1'b1;
          lap_wr_idx  = lap_count_d;
          lap_count_d = lap_count_d + 1'b1;
        end
      end else if (lap_count_d != '0) begin
        if (!lap_view_d) begin
          lap_view_d = 1'b1;
          view_idx_d = '0;
        end else if ((LcW'(view_idx_d) + LcW'(1)) == lap_count_d) begin
          lap_view_d = 1'b0;
          view_idx_d = '0;
        end else begin
          view_idx_d = view_idx_d + 1'b1;
        end
      end
    end
  end

  // The buffer is only written while running, when the view is forced live, so reading
  // the registered buffer here never misses a same-edge write.
  always_comb begin
    lap_sel = lap_buf_q[0];
    for (int i = 0; i < LAP_DEPTH; i++) begin
      if (view_idx_d == IdxW'(i)) lap_sel = lap_buf_q[i];
    end
    display_d = lap_view_d ? lap_sel : count_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_db_q    <= '1;
      db_cnt_q    <= '0;
      press_q     <= '0;
      pre_q       <= '0;
      count_q     <= '0;
      mode_q      <= 1'b0;
      running_q   <= 1'b0;
      alarm_q     <= 1'b0;
      tick_q      <= 1'b0;
      lap_count_q <= '0;
      lap_view_q  <= 1'b0;
      view_idx_q  <= '0;
      display_q   <= '0;
    end else begin
      key_db_q    <= key_db_d;
      db_cnt_q    <= db_cnt_d;
      press_q     <= press_d;
      pre_q       <= pre_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      running_q   <= running_d;
      alarm_q     <= alarm_d;
      tick_q      <= tick_d;
      lap_count_q <= lap_count_d;
      lap_view_q  <= lap_view_d;
      view_idx_q  <= view_idx_d;
      display_q   <= display_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LAP_DEPTH; i++) begin
      if (lap_wr && (lap_wr_idx == LcW'(i))) lap_buf_q[i] <= lap_data;
    end
  end

  assign display_bcd = display_q;
  assign running     = running_q;
  assign lap_count   = lap_count_q;
  assign lap_view    = lap_view_q;
  assign alarm       = alarm_q;
  assign tick        = tick_q;

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Directed bench for stopwatch_lap_timer: expected states are queued when stimulus is
// applied and drained against the outputs at the sampling point.
module tb_stopwatch_lap_timer;

  localparam int unsigned CPT = 4;
  localparam int unsigned DEB = 3;
  localparam int unsigned LD  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_reset = 1'b1;
  logic        key_start_pause = 1'b1;
  logic        key_lap = 1'b1;
  logic        countdown = 1'b0;
  logic [23:0] preset_bcd = 24'd0;
  logic [23:0] display_bcd;
  logic        running;
  logic [1:0]  lap_count;
  logic        lap_view;
  logic        alarm;
  logic        tick;

  always #5 clk = ~clk;

  stopwatch_lap_timer #(
    .CLK_PER_TICK   (CPT),
    .DEBOUNCE_CYCLES(DEB),
    .LAP_DEPTH      (LD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key_reset      (key_reset),
    .key_start_pause(key_start_pause),
    .key_lap        (key_lap),
    .countdown      (countdown),
    .preset_bcd     (preset_bcd),
    .display_bcd    (display_bcd),
    .running        (running),
    .lap_count      (lap_count),
    .lap_view       (lap_view),
    .alarm          (alarm),
    .tick           (tick)
  );

  typedef struct {
    string       tag;
    logic [23:0] disp;
    logic        run;
    logic        alm;
    logic [1:0]  lc;
    logic        lv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [23:0] disp, input logic run,
                              input logic alm, input logic [1:0] lc, input logic lv);
    exp_t e;
    e.tag  = tag;
    e.disp = disp;
    e.run  = run;
    e.alm  = alm;
    e.lc   = lc;
    e.lv   = lv;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".display"}, 32'(display_bcd), 32'(e.disp));
      chk({e.tag, ".running"}, 32'(running), 32'(e.run));
      chk({e.tag, ".alarm"}, 32'(alarm), 32'(e.alm));
      chk({e.tag, ".lap_count"}, 32'(lap_count), 32'(e.lc));
      chk({e.tag, ".lap_view"}, 32'(lap_view), 32'(e.lv));
    end
  endtask

  // Holds the selected keys low for exactly DEB sampling edges, then releases them.
  // Returns at the falling edge just before the edge where the event takes effect.
  task automatic press(input logic [2:0] mask);
    key_reset       = ~mask[0];
    key_start_pause = ~mask[1];
    key_lap         = ~mask[2];
    repeat (DEB) @(negedge clk);
    key_reset       = 1'b1;
    key_start_pause = 1'b1;
    key_lap         = 1'b1;
  endtask

  task automatic wait_tick(input int n, input string tag);
    int seen;
    seen = 0;
    for (int c = 0; c < 200 && seen < n; c++) begin
      @(negedge clk);
      if (tick) seen++;
    end
    chk({tag, ".ticks"}, 32'(seen), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    repeat (2) @(negedge clk);
    expect_state("reset", 24'h000000, 1'b0, 1'b0, 2'd0, 1'b0);
    drain();
    chk("reset.tick", 32'(tick), 32'd0);
    rst = 1'b0;

    // Too-short press is ignored.
    key_start_pause = 1'b0;
    repeat (2) @(negedge clk);
    key_start_pause = 1'b1;
    repeat (5) @(negedge clk);
    expect_state("glitch", 24'h000000, 1'b0, 1'b0, 2'd0, 1'b0);
    drain();

    // Full press: no effect before edge 4, running after it, first tick 4 cycles later.
    press(3'b010);
    expect_state("start_pre", 24'h000000, 1'b0, 1'b0, 2'd0, 1'b0);
    drain();
    @(negedge clk);
    expect_state("start_post", 24'h000000, 1'b1, 1'b0, 2'd0, 1'b0);
    drain();
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n++;
      if (tick) break;
    end
    chk("first_tick.latency", 32'(n), 32'd4);
    expect_state("first_tick", 24'h000001, 1'b1, 1'b0, 2'd0, 1'b0);
    drain();

    // Up wrap: hold the counter at 99:59.99 across a non-tick edge.
    force dut.count_q = 24'h995999;
    @(negedge clk);
    release dut.count_q;
    expect_state("forced", 24'h995999, 1'b1, 1'b0, 2'd0, 1'b0);
    drain();
    wait_tick(1, "wrap");
    expect_state("wrap", 24'h000000, 1'b1, 1'b0, 2'd0, 1'b0);
    drain();

    // Pause landing on a tick edge: update applied, then stopped.
    press(3'b010);
    @(negedge clk);
    expect_state("pause_on_tick", 24'h000001, 1'b0, 1'b0, 2'd0, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    press(3'b001);
    @(negedge clk);
    expect_state("reset_up", 24'h000000, 1'b0, 1'b0, 2'd0, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    // Laps: each capture lands on a tick edge and must store the pre-update value.
    press(3'b010);
    wait_tick(3, "lap_run");
    expect_state("lap_run", 24'h000003, 1'b1, 1'b0, 2'd0, 1'b0);
    drain();
    press(3'b100);
    wait_tick(2, "lap1");
    expect_state("lap1", 24'h000005, 1'b1, 1'b0, 2'd1, 1'b0);
    drain();
    press(3'b100);
    wait_tick(2, "lap2");
    expect_state("lap2", 24'h000007, 1'b1, 1'b0, 2'd2, 1'b0);
    drain();
    press(3'b100);
    wait_tick(1, "lap3");
    expect_state("lap3_dropped", 24'h000008, 1'b1, 1'b0, 2'd2, 1'b0);
    drain();
    press(3'b010);
    @(negedge clk);
    expect_state("lap_pause", 24'h000009, 1'b0, 1'b0, 2'd2, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    press(3'b100);
    @(negedge clk);
    expect_state("view0", 24'h000003, 1'b0, 1'b0, 2'd2, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    press(3'b100);
    @(negedge clk);
    expect_state("view1", 24'h000005, 1'b0, 1'b0, 2'd2, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    press(3'b100);
    @(negedge clk);
    expect_state("view_live", 24'h000009, 1'b0, 1'b0, 2'd2, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    // Countdown to expiry.
    countdown  = 1'b1;
    preset_bcd = 24'h000002;
    press(3'b001);
    @(negedge clk);
    expect_state("cd_load", 24'h000002, 1'b0, 1'b0, 2'd0, 1'b0);
    drain();
    repeat (3) @(negedge clk);
    press(3'b010);
    wait_tick(1, "cd1");
    expect_state("cd1", 24'h000001, 1'b1, 1'b0, 2'd0, 1'b0);
    drain();
    wait_tick(1, "cd0");
    expect_state("cd_expire", 24'h000000, 1'b0, 1'b1, 2'd0, 1'b0);
    drain();
    repeat (3) @(negedge clk);
    press(3'b010);
    @(negedge clk);
    expect_state("cd_start_at_zero", 24'h000000, 1'b0, 1'b0, 2'd0, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    // Preset clamp.
    preset_bcd = 24'hA37F22;
    press(3'b001);
    @(negedge clk);
    expect_state("clamp", 24'h935922, 1'b0, 1'b0, 2'd0, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    // Simultaneous reset and start while stopped: both act, reset first.
    countdown = 1'b0;
    press(3'b011);
    @(negedge clk);
    expect_state("prio", 24'h000000, 1'b1, 1'b0, 2'd0, 1'b0);
    drain();
    wait_tick(1, "prio_run");
    expect_state("prio_run", 24'h000001, 1'b1, 1'b0, 2'd0, 1'b0);
    drain();

    // Asynchronous reset mid-tick, observed before the next rising edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    expect_state("async_rst", 24'h000000, 1'b0, 1'b0, 2'd0, 1'b0);
    drain();
    chk("async_rst.tick", 32'(tick), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
